// File: rtl/inspector_lane_arbiter.sv
// Round-robin packet arbiter/framer: A5A5A5A5 preamble, one 256-bit packet from the granted lane, zero gap.
// Latency: req seen in IDLE at edge E0 -> preamble bit 31 on data_out in cycle after E0; req is level, no backpressure.
module inspector_lane_arbiter #(
  parameter int N_LANES  = 4,
  parameter int GAP_BITS = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_LANES-1:0] i_req,
  input  logic [N_LANES-1:0] i_lane_data,
  output logic [N_LANES-1:0] o_grant,
  output logic [N_LANES-1:0] o_lane_rd,
  output logic               o_data_out,
  output logic               o_frame_start,
  output logic               o_busy,
  output logic [2:0]         o_grant_id,
  output logic [31:0]        o_frames_sent
);

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_PAYLOAD, S_GAP} state_t;

  localparam logic [31:0] PREAMBLE = 32'hA5A5_A5A5;
  localparam logic [7:0]  GAP_LAST = 8'(GAP_BITS - 1);

  state_t             r_state;
  logic [8:0]         r_bit_cnt;
  logic [7:0]         r_gap_cnt;
  logic [N_LANES-1:0] r_grant;
  logic [2:0]         r_grant_id;
  logic [2:0]         r_rr_ptr;
  logic               r_data_out;
  logic               r_frame_start;
  logic               r_busy;
  logic               r_arb_ok;
  logic [31:0]        r_frames_sent;

  logic [7:0]         w_req_pad;
  logic [7:0]         w_data_pad;
  logic [7:0]         w_win_oh;
  logic [2:0]         w_idx;
  logic [2:0]         w_win_id;
  logic               w_win_vld;
  logic               w_done;
  logic               w_pre_bit;
  logic               w_lane_bit;

  assign w_req_pad  = 8'(i_req);
  assign w_data_pad = 8'(i_lane_data);

  // Descending scan so the lane closest above rr_ptr is the last to write, i.e. wins.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_id  = 3'd0;
    w_idx     = 3'd0;
    for (int k = N_LANES; k >= 1; k--) begin
      w_idx = 3'((int'(r_rr_ptr) + k) % N_LANES);
      if (w_req_pad[w_idx]) begin
        w_win_vld = 1'b1;
        w_win_id  = w_idx;
      end
    end
  end

  assign w_win_oh   = 8'd1 << w_win_id;
  assign w_done     = (r_state == S_PAYLOAD) && (r_bit_cnt == 9'd255);
  assign w_pre_bit  = PREAMBLE[~r_bit_cnt[4:0]];
  assign w_lane_bit = w_data_pad[r_grant_id];

  // r_arb_ok keeps the first IDLE cycle after a frame non-arbitrating, so at least one zero bit separates frames.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_bit_cnt     <= 9'd0;
      r_gap_cnt     <= 8'd0;
      r_grant       <= '0;
      r_grant_id    <= 3'd0;
      r_rr_ptr      <= 3'(N_LANES - 1);
      r_data_out    <= 1'b0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
      r_arb_ok      <= 1'b1;
      r_frames_sent <= 32'd0;
    end else begin
      r_frame_start <= 1'b0;
      r_frames_sent <= r_frames_sent + {31'd0, w_done};
      case (r_state)
        S_IDLE: begin
          r_data_out <= 1'b0;
          r_arb_ok   <= 1'b1;
          if (r_arb_ok && w_win_vld) begin
            r_state       <= S_PREAMBLE;
            r_grant       <= w_win_oh[N_LANES-1:0];
            r_grant_id    <= w_win_id;
            r_rr_ptr      <= w_win_id;
            r_data_out    <= PREAMBLE[31];
            r_frame_start <= 1'b1;
            r_busy        <= 1'b1;
            r_bit_cnt     <= 9'd1;
          end
        end
        S_PREAMBLE: begin
          r_data_out <= w_pre_bit;
          if (r_bit_cnt == 9'd31) begin
            r_state   <= S_PAYLOAD;
            r_bit_cnt <= 9'd0;
          end else begin
            r_bit_cnt <= r_bit_cnt + 9'd1;
          end
        end
        S_PAYLOAD: begin
          r_data_out <= w_lane_bit;
          r_bit_cnt  <= r_bit_cnt + 9'd1;
          if (w_done) begin
            r_grant   <= '0;
            r_gap_cnt <= 8'd0;
            r_arb_ok  <= 1'b0;
            if (GAP_BITS == 0) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          r_data_out <= 1'b0;
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_grant       = r_grant;
  assign o_lane_rd     = (r_state == S_PAYLOAD) ? r_grant : '0;
  assign o_data_out    = r_data_out;
  assign o_frame_start = r_frame_start;
  assign o_busy        = r_busy;
  assign o_grant_id    = r_grant_id;
  assign o_frames_sent = r_frames_sent;

endmodule

// File: tb/tb_inspector_lane_arbiter.sv
// Directed bench for inspector_lane_arbiter: one instance with an 8-bit gap, one with no gap.
module tb_inspector_lane_arbiter;

  logic        clk = 1'b0;
  logic        rst, rst0;
  logic [3:0]  req, req0, lane_data, lane_data0;
  logic [3:0]  grant, lane_rd, grant0, lane_rd0;
  logic        data_out, frame_start, busy, data_out0, frame_start0, busy0;
  logic [2:0]  grant_id, grant_id0;
  logic [31:0] frames_sent, frames_sent0;

  logic [255:0] pkt [4];
  logic [7:0]   ptr [4];
  logic [7:0]   ptr0 [4];
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  bit           use0 = 1'b0;

  logic [3:0]  m_grant, m_lane_rd;
  logic        m_data_out, m_frame_start, m_busy;
  logic [2:0]  m_grant_id;
  logic [31:0] m_frames_sent;

  inspector_lane_arbiter #(.N_LANES(4), .GAP_BITS(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_lane_data(lane_data),
    .o_grant(grant), .o_lane_rd(lane_rd), .o_data_out(data_out),
    .o_frame_start(frame_start), .o_busy(busy), .o_grant_id(grant_id),
    .o_frames_sent(frames_sent)
  );

  inspector_lane_arbiter #(.N_LANES(4), .GAP_BITS(0)) dut0 (
    .i_clk(clk), .i_rst(rst0), .i_req(req0), .i_lane_data(lane_data0),
    .o_grant(grant0), .o_lane_rd(lane_rd0), .o_data_out(data_out0),
    .o_frame_start(frame_start0), .o_busy(busy0), .o_grant_id(grant_id0),
    .o_frames_sent(frames_sent0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Lane sources: present bit at the read pointer, advance on each lane_rd strobe.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) ptr[i] <= 8'd0;
      else if (lane_rd[i]) ptr[i] <= ptr[i] + 8'd1;
      if (rst0) ptr0[i] <= 8'd0;
      else if (lane_rd0[i]) ptr0[i] <= ptr0[i] + 8'd1;
    end
  end

  always_comb begin
    lane_data  = 4'd0;
    lane_data0 = 4'd0;
    for (int i = 0; i < 4; i++) begin
      lane_data[i]  = pkt[i][8'd255 - ptr[i]];
      lane_data0[i] = pkt[i][8'd255 - ptr0[i]];
    end
  end

  assign m_grant       = use0 ? grant0 : grant;
  assign m_lane_rd     = use0 ? lane_rd0 : lane_rd;
  assign m_data_out    = use0 ? data_out0 : data_out;
  assign m_frame_start = use0 ? frame_start0 : frame_start;
  assign m_busy        = use0 ? busy0 : busy;
  assign m_grant_id    = use0 ? grant_id0 : grant_id;
  assign m_frames_sent = use0 ? frames_sent0 : frames_sent;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_fs(input string tag, input int budget, output int at);
    int n;
    n = 0;
    while (m_frame_start !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_fs_seen"}, m_frame_start, 1);
    at = cyc;
  endtask

  // Entered at the negedge of the frame_start cycle; leaves at the cycle showing payload bit 256.
  task automatic check_frame(input string tag, input int lane, input logic [31:0] exp_frames,
                             input int drop_c, input bit do_wrap);
    logic [287:0] fr;
    logic [3:0]   oh;
    int           rd, other;
    oh    = 4'b0001 << lane;
    rd    = 0;
    other = 0;
    chk({tag, "_grant"}, m_grant, oh);
    chk({tag, "_grant_id"}, m_grant_id, lane);
    chk({tag, "_busy"}, m_busy, 1);
    for (int c = 1; c <= 288; c++) begin
      fr[288 - c] = m_data_out;
      if (m_lane_rd[lane]) rd++;
      other += $countones(m_lane_rd & ~oh);
      if (drop_c == c) req = 4'b0000;
      if (do_wrap && c == 10) force dut0.r_frames_sent = 32'hFFFF_FFFF;
      if (do_wrap && c == 11) release dut0.r_frames_sent;
      if (do_wrap && c == 12) chk({tag, "_wrap_preset"}, m_frames_sent, 32'hFFFF_FFFF);
      if (c < 288) @(negedge clk);
    end
    chk({tag, "_preamble"}, fr[287:256], 32'hA5A5_A5A5);
    chk({tag, "_payload_bit_errs"}, $countones(fr[255:0] ^ pkt[lane]), 0);
    chk({tag, "_lane_rd_cycles"}, rd, 256);
    chk({tag, "_other_lane_rd"}, other, 0);
    chk({tag, "_grant_cleared"}, m_grant, 0);
    chk({tag, "_frames_sent"}, m_frames_sent, exp_frames);
  endtask

  int order [6] = '{0, 1, 3, 0, 1, 3};
  int at, prev, ones, fs_cnt;

  initial begin
    rst = 1'b1; rst0 = 1'b1; req = 4'd0; req0 = 4'd0;
    for (int i = 0; i < 4; i++) pkt[i] = {8{32'h9E37_79B9 * (i + 1)}};
    pkt[2][191:176] = 16'd22;
    pkt[2][119:112] = 8'd7;
    repeat (2) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_lane_rd", lane_rd, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_frames_sent", frames_sent, 0);
    rst = 1'b0; rst0 = 1'b0;

    // Single lane 2; preamble must start one edge after req is seen.
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    chk("single_latency_fs", frame_start, 1);
    check_frame("single", 2, 1, 0, 0);
    req  = 4'b0000;
    ones = 0;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      ones += data_out;
    end
    chk("single_busy_in_gap", busy, 1);
    @(negedge clk);
    ones += data_out;
    chk("single_busy_idle", busy, 0);
    chk("single_gap_zeros", ones, 0);
    fs_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      fs_cnt += frame_start;
    end
    chk("single_no_refire", fs_cnt, 0);

    // Three lanes held: round-robin 0,1,3 with fixed frame spacing.
    do_reset();
    req  = 4'b1011;
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      wait_fs("rr", 400, at);
      if (k > 0) chk("rr_spacing", at - prev, 297);
      prev = at;
      check_frame("rr", order[k], 32'(k + 1), 0, 0);
    end
    req = 4'b0000;

    // Lane 2 joins during lane 1's frame and is served next.
    do_reset();
    req = 4'b0010;
    wait_fs("fair1", 20, at);
    req = 4'b0110;
    check_frame("fair1", 1, 1, 0, 0);
    wait_fs("fair2", 400, at);
    check_frame("fair2", 2, 2, 0, 0);
    wait_fs("fair3", 400, at);
    req = 4'b0000;
    check_frame("fair3", 1, 3, 0, 0);

    // Lane 0 drops req at payload bit 100 (frame cycle 132).
    do_reset();
    req = 4'b0001;
    wait_fs("drop", 20, at);
    check_frame("drop", 0, 1, 132, 0);
    fs_cnt = 0;
    repeat (320) begin
      @(negedge clk);
      fs_cnt += frame_start;
    end
    chk("drop_no_refire", fs_cnt, 0);
    chk("drop_frames_hold", frames_sent, 1);

    // Reset at payload bit 50 of a lane-3 frame, then lanes 1 and 2 request.
    req = 4'b1000;
    wait_fs("rstmid", 400, at);
    repeat (81) @(negedge clk);
    chk("rstmid_granted", grant_id, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_grant", grant, 0);
    chk("rstmid_lane_rd", lane_rd, 0);
    chk("rstmid_data_out", data_out, 0);
    chk("rstmid_frame_start", frame_start, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_grant_id", grant_id, 0);
    chk("rstmid_frames_sent", frames_sent, 0);
    rst = 1'b0;
    req = 4'b0110;
    @(negedge clk);
    chk("rstmid_latency_fs", frame_start, 1);
    check_frame("rstmid", 1, 1, 0, 0);
    req = 4'b0000;

    // No gap: exactly one zero bit between frames, and counter wrap.
    use0 = 1'b1;
    req0 = 4'b0001;
    wait_fs("g0", 20, at);
    check_frame("g0a", 0, 1, 0, 0);
    @(negedge clk);
    chk("g0_idle_bit", data_out0, 0);
    chk("g0_idle_no_fs", frame_start0, 0);
    @(negedge clk);
    chk("g0_back_to_back_fs", frame_start0, 1);
    check_frame("g0b", 0, 0, 0, 1);
    req0 = 4'b0000;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/inspector_lane_arbiter.md
# inspector_lane_arbiter

Packet-granular round-robin arbiter and framer that shares the single serial `data` input of the packet inspector between `N_LANES` serial packet sources. It inserts the A5A5A5A5 start pattern itself, then streams exactly one 256-bit packet from the granted lane, then a zero-filled gap. This guarantees the inspector always sees clean, non-interleaved frames. It sits directly in front of the inspector: `data_out` drives the inspector's `data` pin on the same `clk`.

## Interface
- `N_LANES`, 4: number of requesting serial sources (2..8).
- `GAP_BITS`, 8: zero bits driven after each packet before the next arbitration (0..255).
- `clk`  in  1: single clock; all state changes on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `req`  in  N_LANES: lane i has a full 256-bit packet ready; level-sensitive.
- `lane_data`  in  N_LANES: serial payload bit from each lane, MSB (packet bit 1) first.
- `grant`  out  N_LANES: one-hot; lane currently owning the stream; all-zero when idle.
- `lane_rd`  out  N_LANES: one-hot strobe; lane i must present its next payload bit on `lane_data[i]` this cycle, then advance.
- `data_out`  out  1: serial stream to the inspector.
- `frame_start`  out  1: one-cycle pulse in the cycle `data_out` shows the first preamble bit.
- `busy`  out  1: high from the grant edge until return to IDLE.
- `grant_id`  out  3: index of granted lane; holds the last value when idle.
- `frames_sent`  out  32: completed frames, wraps 0xFFFFFFFF -> 0.

## Operation
- FSM states: IDLE, PREAMBLE, PAYLOAD, GAP. A 9-bit bit counter and an 8-bit gap counter.
- IDLE: `data_out`=0. If `req` is nonzero at an edge, select the first requesting lane searching upward (with wrap) from `rr_ptr+1`. On that edge:
  - `grant` is set one-hot and `grant_id` is set.
  - `rr_ptr` is updated to the winner.
  - the FSM moves to PREAMBLE and `data_out` is set to preamble bit 31.
  - `frame_start`=1 and `busy`=1.
- PREAMBLE: `data_out` shifts out 0xA5A5A5A5 MSB first (1,0,1,0,0,1,0,1 repeated four times), 32 cycles total.
- PAYLOAD: `lane_rd[grant_id]` is high for exactly 256 consecutive cycles, starting in the cycle `data_out` shows preamble bit 0. Each `lane_data[grant_id]` bit sampled on the closing edge appears on `data_out` the next cycle. `data_out` is therefore continuous: 32 preamble bits, then 256 payload bits.
- Other lanes' `lane_data` is ignored. `lane_rd` is zero for non-granted lanes.
- The edge that registers payload bit 256 also clears `grant` and `lane_rd`, increments `frames_sent`, and enters GAP.
- If `GAP_BITS`=0, the FSM goes directly to IDLE.
- GAP: `data_out`=0 for `GAP_BITS` cycles, then IDLE.
- IDLE always lasts at least one cycle: the arbitration cycle.
- `req` changes during a frame are ignored. A lane that drops `req` mid-frame is still read for all 256 bits.
- A new or held `req` is honoured only at the next IDLE.
- Round-robin: the lane that just finished has lowest priority. A single continuously requesting lane may be granted back-to-back.

## Timing
- Reset (edge with `rst`=1, from any state, including mid-frame) produces:
  - state IDLE.
  - `grant`=0, `lane_rd`=0, `data_out`=0, `frame_start`=0, `busy`=0.
  - `grant_id`=0, `frames_sent`=0.
  - `rr_ptr`=N_LANES-1, so lane 0 wins first.
- A partially sent frame is abandoned. No count is recorded.
- Latency: `req` high in IDLE at edge E0 -> first preamble bit on `data_out` during cycle E0..E0+1.
- Payload bit n (1..256) appears on `data_out` in cycle 32+n after E0.
- Minimum spacing between `frame_start` pulses: 288+GAP_BITS+1 cycles.
- All outputs are registered except `lane_rd`, which is decoded from state/`grant_id`. `lane_rd` is glitch-free within a cycle.

## Test plan
- **Single lane:** reset, then `req[2]`=1 with a packet having port 22 at bits 65-80 and session 7 at bits 137-144.
  - `frame_start` is seen once; `data_out` carries A5A5A5A5 then the exact 256 bits.
  - `lane_rd[2]` is high 256 cycles; `frames_sent`=1.
  - Inspector in loop: `ssh_cnt`=1, `total_cnt`=1.
- **Simultaneous requests:** `req`=4'b1011 held.
  - Grant order is 0,1,3,0,1,3.
  - `frame_start` spacing is exactly 297 cycles with `GAP_BITS`=8.
- **Fairness:** lane 1 requests continuously; lane 2 raises `req` mid-frame of lane 1. The next grant goes to lane 2, then back to lane 1.
- **Request drop:** `req[0]` deasserts at payload bit 100. The frame still completes with 256 `lane_rd` cycles; `frames_sent` increments by 1.
- **Reset mid-frame:** `rst`=1 at payload bit 50.
  - The next cycle shows all outputs at reset values and `frames_sent`=0.
  - With `req`=4'b0110 after release, lane 1 is granted first.
- **GAP_BITS=0 and wrap:**
  - Back-to-back frames are separated by exactly 1 idle zero bit.
  - `frames_sent` forced to 0xFFFFFFFF wraps to 0 on the next completion.
